// File: rtl/sao_stat_acc_n.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : sao_stat_acc_n
//  Brief    : SAO band-offset statistics accumulator. Per CTU, gathers a
//             saturating signed diff sum and a pixel count for every category
//             over PIX_N lanes per beat, then drains one result beat per
//             category in ascending order.
//  Revision : 1.0 - initial release
// ============================================================================
module sao_stat_acc_n #(
    parameter int PIX_N         = 8,
    parameter int diff_clip_bit = 4,
    parameter int n_bo_type     = 5,
    parameter int SUM_W         = 18,
    parameter int CNT_W         = 13
) (
    input  logic                                 clk,
    input  logic                                 arst_n,
    input  logic                                 start,
    input  logic                                 in_valid,
    input  logic                                 in_last,
    input  logic [PIX_N-1:0]                     lane_en,
    input  logic [PIX_N*n_bo_type-1:0]           cate,
    input  logic [PIX_N*(diff_clip_bit+1)-1:0]   diff,
    input  logic                                 rd_ready,
    output logic                                 busy,
    output logic                                 out_valid,
    output logic [n_bo_type-1:0]                 out_cate,
    output logic signed [SUM_W-1:0]              out_sum,
    output logic [CNT_W-1:0]                     out_cnt,
    output logic                                 out_last
);

    localparam int N_CATE = 2 ** n_bo_type;
    localparam int DW     = diff_clip_bit + 1;
    // One beat can carry at most 16 lanes, so 4 extra bits plus margin hold
    // the largest per-category partial sum; 5 bits hold a count of 16.
    localparam int PW     = DW + 5;
    localparam int PCW    = 5;
    localparam int AW     = ((SUM_W > PW) ? SUM_W : PW) + 1;
    localparam int CAW    = ((CNT_W > PCW) ? CNT_W : PCW) + 1;

    localparam logic signed [AW-1:0] SMAX = {{(AW-SUM_W+1){1'b0}}, {(SUM_W-1){1'b1}}};
    localparam logic signed [AW-1:0] SMIN = {{(AW-SUM_W+1){1'b1}}, {(SUM_W-1){1'b0}}};
    localparam logic [CAW-1:0]       CMAX = {{(CAW-CNT_W){1'b0}}, {CNT_W{1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACC   = 2'd1,
        S_FLUSH = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic signed [PW-1:0]    part_sum_d [N_CATE];
    logic [PCW-1:0]          part_cnt_d [N_CATE];
    logic signed [PW-1:0]    p1_sum_q   [N_CATE];
    logic [PCW-1:0]          p1_cnt_q   [N_CATE];
    logic                    p1_vld_q;

    logic signed [SUM_W-1:0] sum_q [N_CATE];
    logic signed [SUM_W-1:0] sum_d [N_CATE];
    logic [CNT_W-1:0]        cnt_q [N_CATE];
    logic [CNT_W-1:0]        cnt_d [N_CATE];

    logic [n_bo_type-1:0]    rd_idx_q;

    logic w_accept;
    logic w_clear;
    logic w_hs;

    // Beats count only while accumulating; start is honoured only from IDLE.
    assign w_accept = (state_q == S_ACC) && in_valid;
    assign w_clear  = (state_q == S_IDLE) && start;
    assign w_hs     = out_valid && rd_ready;

    // State register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and result-port decode; ports are forced to 0 outside DRAIN.
    always_comb begin
        state_d   = state_q;
        busy      = (state_q != S_IDLE);
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_cate  = '0;
        out_sum   = '0;
        out_cnt   = '0;
        case (state_q)
            S_IDLE:  if (start) state_d = S_ACC;
            S_ACC:   if (in_valid && in_last) state_d = S_FLUSH;
            S_FLUSH: state_d = S_DRAIN;
            S_DRAIN: begin
                out_valid = 1'b1;
                out_last  = &rd_idx_q;
                out_cate  = rd_idx_q;
                out_sum   = sum_q[rd_idx_q];
                out_cnt   = cnt_q[rd_idx_q];
                if (rd_ready && (&rd_idx_q)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Stage 1 combine: fold every enabled lane into its category's partial.
    always_comb begin
        logic [n_bo_type-1:0] lane_c;
        logic [DW-1:0]        lane_d;
        lane_c = '0;
        lane_d = '0;
        for (int c = 0; c < N_CATE; c++) begin
            part_sum_d[c] = '0;
            part_cnt_d[c] = '0;
        end
        for (int l = 0; l < PIX_N; l++) begin
            lane_c = cate[l*n_bo_type +: n_bo_type];
            lane_d = diff[l*DW +: DW];
            if (lane_en[l]) begin
                part_sum_d[lane_c] = part_sum_d[lane_c] + {{(PW-DW){lane_d[DW-1]}}, lane_d};
                part_cnt_d[lane_c] = part_cnt_d[lane_c] + PCW'(1);
            end
        end
    end

    // Stage 1 register: capture partials of an accepted beat.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            p1_vld_q <= 1'b0;
            for (int c = 0; c < N_CATE; c++) begin
                p1_sum_q[c] <= '0;
                p1_cnt_q[c] <= '0;
            end
        end else begin
            p1_vld_q <= w_accept;
            if (w_accept) begin
                for (int c = 0; c < N_CATE; c++) begin
                    p1_sum_q[c] <= part_sum_d[c];
                    p1_cnt_q[c] <= part_cnt_d[c];
                end
            end
        end
    end

    // Stage 2 add with clamping; the add is one bit wider than either operand
    // so the overflow is visible before clamping.
    always_comb begin
        logic signed [AW-1:0] ws;
        logic [CAW-1:0]       wc;
        ws = '0;
        wc = '0;
        for (int c = 0; c < N_CATE; c++) begin
            ws = {{(AW-SUM_W){sum_q[c][SUM_W-1]}}, sum_q[c]}
               + {{(AW-PW){p1_sum_q[c][PW-1]}}, p1_sum_q[c]};
            if (ws > SMAX) begin
                sum_d[c] = SMAX[SUM_W-1:0];
            end else if (ws < SMIN) begin
                sum_d[c] = SMIN[SUM_W-1:0];
            end else begin
                sum_d[c] = ws[SUM_W-1:0];
            end
            wc = {{(CAW-CNT_W){1'b0}}, cnt_q[c]} + {{(CAW-PCW){1'b0}}, p1_cnt_q[c]};
            cnt_d[c] = (wc > CMAX) ? CMAX[CNT_W-1:0] : wc[CNT_W-1:0];
        end
    end

    // Accumulators: cleared when a CTU starts, updated by each stage-1 beat.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int c = 0; c < N_CATE; c++) begin
                sum_q[c] <= '0;
                cnt_q[c] <= '0;
            end
        end else if (w_clear) begin
            for (int c = 0; c < N_CATE; c++) begin
                sum_q[c] <= '0;
                cnt_q[c] <= '0;
            end
        end else if (p1_vld_q) begin
            for (int c = 0; c < N_CATE; c++) begin
                sum_q[c] <= sum_d[c];
                cnt_q[c] <= cnt_d[c];
            end
        end
    end

    // Drain pointer: parked at 0 outside DRAIN, steps on each handshake.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rd_idx_q <= '0;
        end else if (state_q != S_DRAIN) begin
            rd_idx_q <= '0;
        end else if (w_hs) begin
            rd_idx_q <= rd_idx_q + n_bo_type'(1);
        end
    end

endmodule
`default_nettype wire
